// File: rtl/nibser_pkg.sv
// Shared definitions for the nibble-serial adder: FSM states and nibble width.
package nibser_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder.sv
// Nibble-serial add/subtract engine. Operands are fed LSB nibble first to an
// external 4-bit carry-select adder; its sum/carry are folded back here into a
// WIDTH-bit result. Result and flags are held registered until taken.
module nibble_serial_adder
  import nibser_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  input  logic             op_sub,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / NIB_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_nxt_s;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic             last_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;

  // Final nibble of the operation: the result is complete after this edge.
  assign last_s    = (state_r == RUN) && (cnt_r == CW'(N - 1));
  // New nibble enters at the top; after N shifts the result sits in place.
  assign res_nxt_s = {add_s, res_r[WIDTH-1:NIB_W]};

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

  // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = RUN;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Drive the external adder only while a nibble is in flight.
  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state_r == RUN) begin
      add_a   = a_r[NIB_W-1:0];
      add_b   = b_r[NIB_W-1:0];
      add_cin = carry_r;
    end else begin
      add_a   = 4'h0;
      add_b   = 4'h0;
      add_cin = 1'b0;
    end
  end

  // Operand capture, per-nibble shift, carry chaining and result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            // Subtract is A + ~B + 1, so op_cin is not used for it.
            a_r     <= op_a;
            b_r     <= op_sub ? ~op_b : op_b;
            carry_r <= op_sub ? 1'b1 : op_cin;
            res_r   <= '0;
            cnt_r   <= '0;
            a_msb_r <= op_a[WIDTH-1];
            b_msb_r <= op_sub ? ~op_b[WIDTH-1] : op_b[WIDTH-1];
          end
        end
        RUN: begin
          a_r     <= a_r >> NIB_W;
          b_r     <= b_r >> NIB_W;
          res_r   <= res_nxt_s;
          carry_r <= add_cout;
          cnt_r   <= cnt_r + CW'(1);
        end
        DONE: begin
          res_r <= res_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  // Registered result/flags: loaded on the last nibble, cleared on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
    end else if (last_s) begin
      out_valid_r <= 1'b1;
      sum_r       <= res_nxt_s;
      cout_r      <= add_cout;
      zero_r      <= (res_nxt_s == '0);
      ovf_r       <= (a_msb_r == b_msb_r) && (add_s[NIB_W-1] != a_msb_r);
    end else if ((state_r == DONE) && out_ready) begin
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16), closing the loop
// through a behavioural 4-bit carry-select adder.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_cin;
  logic        op_sub;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_s;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  int tests = 0;
  int fails = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  // External 4-bit carry-select adder: both carry cases precomputed, cin picks.
  logic [4:0] sel0_s;
  logic [4:0] sel1_s;
  always_comb begin
    sel0_s = {1'b0, add_a} + {1'b0, add_b};
    sel1_s = {1'b0, add_a} + {1'b0, add_b} + 5'd1;
    if (add_cin) {add_cout, add_s} = sel1_s;
    else         {add_cout, add_s} = sel0_s;
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ovalid"}, int'(out_valid), 0);
    check({tag, "_sum"}, int'(sum), 0);
    check({tag, "_flags"}, int'({cout, ovf, zero}), 0);
    check({tag, "_addin"}, int'({add_a, add_b, add_cin}), 0);
  endtask

  // Run one operation; reference computed with plain 17-bit arithmetic.
  // When hold is set, the result is left pending in DONE.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub, input bit hold,
                       input string tag);
    int be, c, full, exp_sum, exp_cout, exp_ovf, lat, mask, cin_k;
    be       = sub ? int'(~b) & 32'hFFFF : int'(b);
    c        = sub ? 1 : int'(cin);
    full     = int'(a) + be + c;
    exp_sum  = full & 32'hFFFF;
    exp_cout = (full >> 16) & 1;
    exp_ovf  = (((a >> 15) & 1) == ((be >> 15) & 1)) &&
               (((exp_sum >> 15) & 1) != ((a >> 15) & 1)) ? 1 : 0;
    check({tag, "_inready"}, int'(in_ready), 1);
    op_a = a; op_b = b; op_cin = cin; op_sub = sub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op_a = 16'($urandom); op_b = 16'($urandom);
    op_cin = 1'($urandom); op_sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (lat < 4) begin
        mask  = (1 << (4 * lat)) - 1;
        cin_k = (((int'(a) & mask) + (be & mask) + c) >> (4 * lat)) & 1;
        check({tag, "_adda"}, int'(add_a), (int'(a) >> (4 * lat)) & 15);
        check({tag, "_addb"}, int'(add_b), (be >> (4 * lat)) & 15);
        check({tag, "_addcin"}, int'(add_cin), cin_k);
        check({tag, "_run_ready"}, int'(in_ready), 0);
      end
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_sum"}, int'(sum), exp_sum);
    check({tag, "_cout"}, int'(cout), exp_cout);
    check({tag, "_ovf"}, int'(ovf), exp_ovf);
    check({tag, "_zero"}, int'(zero), (exp_sum == 0) ? 1 : 0);
    check({tag, "_done_ready"}, int'(in_ready), 0);
    check({tag, "_done_addin"}, int'({add_a, add_b, add_cin}), 0);
    if (!hold) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_idle_outputs({tag, "_rel"});
      check({tag, "_rel_ready"}, int'(in_ready), 1);
    end
  endtask

  initial begin
    logic [15:0] held_sum;
    logic [2:0]  held_flags;
    rst_n = 1'b0; in_valid = 1'b1; op_a = 16'h1234; op_b = 16'h1111;
    op_cin = 1'b0; op_sub = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset");
    check("reset_ready", int'(in_ready), 1);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, "add_basic");
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, "carry_chain");
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, "ovf_add");
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, "ovf_sub");
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, "sub_borrow");

    // Hold in DONE with in_valid asserted and operands wiggling.
    do_op(16'h0F0F, 16'h1010, 1'b1, 1'b0, 1'b1, "hold");
    held_sum   = sum;
    held_flags = {cout, ovf, zero};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; op_a = 16'($urandom); op_b = 16'($urandom);
      tick();
      check("hold_valid", int'(out_valid), 1);
      check("hold_sum", int'(sum), int'(held_sum));
      check("hold_flags", int'({cout, ovf, zero}), int'(held_flags));
      check("hold_ready", int'(in_ready), 0);
    end
    // Release edge with in_valid still high: must not accept on this edge.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("release_ready", int'(in_ready), 1);
    check_idle_outputs("release");
    do_op(16'h0102, 16'h0304, 1'b0, 1'b0, 1'b0, "after_release");

    // Abort by reset after two nibbles.
    op_a = 16'h1234; op_b = 16'h1111; op_cin = 1'b0; op_sub = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("abort_running", int'(in_ready), 0);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort_async");
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_valid", int'(out_valid), 0);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, "post_reset");

    for (int i = 0; i < 12; i++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            1'b0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
